// File: rtl/mmio_uart_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : mmio_uart_tx_if
// Brief    : Data-memory bus between the single-cycle core and the UART TX block.
// Revision : 1.0
// ============================================================================
interface mmio_uart_tx_if;
  logic        MemWrite;
  logic [31:0] Mem_WrAddr;
  logic [31:0] Mem_WrData;
  logic        io_sel;
  logic [31:0] io_rdata;

  modport master (
    output MemWrite,
    output Mem_WrAddr,
    output Mem_WrData,
    input  io_sel,
    input  io_rdata
  );

  modport slave (
    input  MemWrite,
    input  Mem_WrAddr,
    input  Mem_WrData,
    output io_sel,
    output io_rdata
  );
endinterface
`default_nettype wire

// File: rtl/mmio_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : mmio_uart_tx
// Brief    : Memory-mapped 8N1 UART transmitter with a small TX FIFO.
// Revision : 1.0
// ============================================================================
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4
) (
  input  wire logic     clk,
  input  wire logic     reset,
  mmio_uart_tx_if.slave bus,
  output logic          tx,
  output logic          tx_busy
);

  localparam int c_PTR_W  = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W  = c_PTR_W + 1;
  localparam int c_BAUD_W = $clog2(CLKS_PER_BIT);

  localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [c_CNT_W-1:0]  c_FULL      = c_CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] c_OFS_TXDATA = 2'd0;
  localparam logic [1:0] c_OFS_STATUS = 2'd1;

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_START = 2'd1;
  localparam logic [1:0] c_DATA  = 2'd2;
  localparam logic [1:0] c_STOP  = 2'd3;

  logic [7:0]          r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0]  r_wr_ptr;
  logic [c_PTR_W-1:0]  r_rd_ptr;
  logic [c_CNT_W-1:0]  r_count;
  logic                r_overflow;

  logic [1:0]          r_state;
  logic [c_BAUD_W-1:0] r_baud;
  logic [2:0]          r_bit_cnt;
  logic [7:0]          r_shift;
  logic                r_tx;
  logic                r_busy;

  logic                w_io_sel;
  logic [1:0]          w_offset;
  logic                w_full;
  logic                w_empty;
  logic                w_push_req;
  logic                w_push;
  logic                w_pop;
  logic                w_clr_ovf;
  logic [7:0]          w_head;
  logic [31:0]         w_status;
  logic                w_baud_done;
  logic [1:0]          w_state_next;
  logic [c_BAUD_W-1:0] w_baud_next;
  logic [2:0]          w_bit_cnt_next;
  logic [7:0]          w_shift_next;
  logic                w_tx_next;
  logic                w_busy_next;
  logic                w_unused_bits;

  // ---------------------------------------------------------------- decode
  assign w_io_sel   = (bus.Mem_WrAddr[31:4] == BASE_ADDR[31:4]);
  assign w_offset   = bus.Mem_WrAddr[3:2];
  assign w_full     = (r_count == c_FULL);
  assign w_empty    = (r_count == '0);
  assign w_push_req = bus.MemWrite && w_io_sel && (w_offset == c_OFS_TXDATA);
  assign w_push     = w_push_req && !w_full;
  assign w_clr_ovf  = bus.MemWrite && w_io_sel && (w_offset == c_OFS_STATUS)
                      && bus.Mem_WrData[3];
  assign w_head     = r_mem[r_rd_ptr];
  assign w_status   = {28'b0, r_overflow, r_busy, w_empty, w_full};

  assign bus.io_sel   = w_io_sel;
  assign bus.io_rdata = (w_io_sel && (w_offset == c_OFS_STATUS)) ? w_status : 32'b0;

  assign w_unused_bits = ^{bus.Mem_WrAddr[1:0], bus.Mem_WrData[31:8]};

  // ------------------------------------------------------------------ FIFO
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.Mem_WrData[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // A dropped byte wins over a same-edge clear so the loss is never hidden.
      if (w_push_req && w_full) r_overflow <= 1'b1;
      else if (w_clr_ovf)       r_overflow <= 1'b0;
    end
  end

  // --------------------------------------------------------- shifter state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= c_IDLE;
      r_baud    <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_baud    <= w_baud_next;
      r_bit_cnt <= w_bit_cnt_next;
      r_shift   <= w_shift_next;
      r_tx      <= w_tx_next;
      r_busy    <= w_busy_next;
    end
  end

  assign w_baud_done = (r_baud == c_BAUD_LAST);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_IDLE:  if (!w_empty) w_state_next = c_START;
      c_START: if (w_baud_done) w_state_next = c_DATA;
      c_DATA:  if (w_baud_done && (r_bit_cnt == 3'd7)) w_state_next = c_STOP;
      c_STOP:  if (w_baud_done) w_state_next = w_empty ? c_IDLE : c_START;
      default: w_state_next = c_IDLE;
    endcase
  end

  // Outputs are computed from the next state so tx/tx_busy can be registered
  // without adding a cycle of latency.
  always_comb begin
    w_pop          = 1'b0;
    w_bit_cnt_next = r_bit_cnt;
    w_shift_next   = r_shift;
    w_baud_next    = r_baud + 1'b1;
    if ((r_state == c_IDLE) || (w_state_next != r_state) || w_baud_done)
      w_baud_next = '0;

    case (r_state)
      c_IDLE: begin
        if (!w_empty) begin
          w_pop          = 1'b1;
          w_shift_next   = w_head;
          w_bit_cnt_next = '0;
        end
      end
      c_DATA: begin
        if (w_baud_done) begin
          w_shift_next   = r_shift >> 1;
          w_bit_cnt_next = r_bit_cnt + 1'b1;
        end
      end
      c_STOP: begin
        if (w_baud_done && !w_empty) begin
          w_pop          = 1'b1;
          w_shift_next   = w_head;
          w_bit_cnt_next = '0;
        end
      end
      default: ;
    endcase

    case (w_state_next)
      c_START: w_tx_next = 1'b0;
      c_DATA:  w_tx_next = w_shift_next[0];
      default: w_tx_next = 1'b1;
    endcase
    w_busy_next = (w_state_next != c_IDLE);
  end

  assign tx      = r_tx;
  assign tx_busy = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mmio_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmio_uart_tx
// Brief    : Scoreboard bench for mmio_uart_tx with a cycle-accurate frame monitor.
// Revision : 1.0
// ============================================================================
module tb_mmio_uart_tx;
  localparam int          C      = 4;
  localparam int          DEPTH  = 4;
  localparam logic [31:0] TXDATA = 32'hFFFF_0000;
  localparam logic [31:0] STATUS = 32'hFFFF_0004;

  logic clk;
  logic reset;
  logic tx;
  logic tx_busy;

  mmio_uart_tx_if bus();

  mmio_uart_tx #(
    .BASE_ADDR   (32'hFFFF_0000),
    .CLKS_PER_BIT(C),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus.slave),
    .tx     (tx),
    .tx_busy(tx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int fill_t0  = 0;

  logic [9:0] exp_q[$];
  logic [9:0] rx_q[$];
  int         rx_start_q[$];

  always @(posedge clk) cyc++;

  // Frame monitor: samples mid-bit; a frame is {stop, data[7:0], start}.
  int         mon_i;
  bit         mon_act;
  logic [9:0] mon_frame;
  always @(negedge clk or negedge reset) begin
    if (!reset) begin
      mon_act = 1'b0;
      mon_i   = 0;
    end else begin
      if (!mon_act && tx === 1'b0) begin
        mon_act   = 1'b1;
        mon_i     = 0;
        mon_frame = '0;
        rx_start_q.push_back(cyc);
      end
      if (mon_act) begin
        if (mon_i % C == C / 2) mon_frame[mon_i / C] = tx;
        if (mon_i == 10 * C - 1) begin
          mon_act = 1'b0;
          rx_q.push_back(mon_frame);
        end
        mon_i++;
      end
    end
  end

  function automatic logic [9:0] frame_of(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    bus.Mem_WrAddr = a;
    bus.Mem_WrData = d;
    bus.MemWrite   = 1'b1;
    @(negedge clk);
    bus.MemWrite   = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, output logic [31:0] rd, output logic sel);
    bus.MemWrite   = 1'b0;
    bus.Mem_WrAddr = a;
    #1;
    rd  = bus.io_rdata;
    sel = bus.io_sel;
  endtask

  task automatic wait_rx(input int n, input int budget);
    int k;
    k = 0;
    while (rx_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic test_reset;
    logic [31:0] rd;
    logic        sel;
    reset = 1'b0;
    bus.MemWrite = 1'b0;
    bus.Mem_WrAddr = '0;
    bus.Mem_WrData = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (tx !== 1'b1) $display("FAIL reset_tx: got %b expected 1", tx); else n_pass++;
    n_checks++;
    if (tx_busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", tx_busy); else n_pass++;
    load(STATUS, rd, sel);
    n_checks++;
    if (rd !== 32'h2) $display("FAIL reset_status: got %h expected 00000002", rd); else n_pass++;
    n_checks++;
    if (sel !== 1'b1) $display("FAIL reset_io_sel: got %b expected 1", sel); else n_pass++;
  endtask

  task automatic test_single_frame;
    int          t0;
    int          st;
    logic [9:0]  got;
    logic [9:0]  exp;
    logic [31:0] rd;
    logic        sel;
    exp_q.push_back(frame_of(8'h55));
    store(TXDATA, 32'h55);
    t0 = cyc;
    while (cyc < t0 + 10 * C) @(negedge clk);
    n_checks++;
    if (tx_busy !== 1'b1 || tx !== 1'b1)
      $display("FAIL single_last_stop: got busy=%b tx=%b expected busy=1 tx=1", tx_busy, tx);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (tx_busy !== 1'b0) $display("FAIL single_busy_fall: got %b expected 0", tx_busy); else n_pass++;
    wait_rx(1, 20);
    n_checks++;
    if (rx_q.size() != 1 || rx_start_q.size() != 1)
      $display("FAIL single_count: got %0d frames expected 1", rx_q.size());
    else begin
      n_pass++;
      got = rx_q.pop_front();
      exp = exp_q.pop_front();
      st  = rx_start_q.pop_front();
      n_checks++;
      if (got !== exp) $display("FAIL single_frame: got %b expected %b", got, exp); else n_pass++;
      n_checks++;
      if (st != t0 + 1) $display("FAIL single_start_cycle: got %0d expected %0d", st, t0 + 1); else n_pass++;
    end
    load(STATUS, rd, sel);
    n_checks++;
    if (rd !== 32'h2) $display("FAIL single_status: got %h expected 00000002", rd); else n_pass++;
  endtask

  task automatic test_fill_overflow;
    logic [31:0] rd;
    logic        sel;
    for (int i = 1; i <= 6; i++) begin
      if (i <= DEPTH + 1) exp_q.push_back(frame_of(8'(i)));
      store(TXDATA, 32'(i));
      if (i == 1) fill_t0 = cyc;
    end
    load(STATUS, rd, sel);
    n_checks++;
    if (rd !== 32'hD) $display("FAIL fill_status: got %h expected 0000000d", rd); else n_pass++;
  endtask

  task automatic test_clear_overflow;
    logic [31:0] rd;
    logic        sel;
    store(STATUS, 32'h8);
    load(STATUS, rd, sel);
    n_checks++;
    if (rd[3] !== 1'b0) $display("FAIL clear_ovf_bit: got %b expected 0", rd[3]); else n_pass++;
    n_checks++;
    if (rd !== 32'h5) $display("FAIL clear_other_bits: got %h expected 00000005", rd); else n_pass++;
  endtask

  task automatic test_back_to_back;
    int          n;
    int          st;
    int          exp_st;
    logic [9:0]  got;
    logic [9:0]  exp;
    logic [31:0] rd;
    logic        sel;
    wait_rx(5, 250);
    n = rx_q.size();
    n_checks++;
    if (n != 5 || rx_start_q.size() != 5)
      $display("FAIL b2b_count: got %0d frames expected 5", n);
    else n_pass++;
    exp_st = fill_t0 + 1;
    for (int k = 0; k < n && exp_q.size() > 0 && rx_start_q.size() > 0; k++) begin
      got = rx_q.pop_front();
      exp = exp_q.pop_front();
      st  = rx_start_q.pop_front();
      n_checks++;
      if (got !== exp) $display("FAIL b2b_frame%0d: got %b expected %b", k, got, exp); else n_pass++;
      n_checks++;
      if (st != exp_st) $display("FAIL b2b_start%0d: got %0d expected %0d", k, st, exp_st); else n_pass++;
      exp_st += 10 * C;
    end
    repeat (20) @(negedge clk);
    n_checks++;
    if (rx_q.size() != 0 || rx_start_q.size() != 0)
      $display("FAIL b2b_extra_frame: got %0d extra starts expected 0", rx_start_q.size());
    else n_pass++;
    load(STATUS, rd, sel);
    n_checks++;
    if (rd !== 32'h2) $display("FAIL b2b_status: got %h expected 00000002", rd); else n_pass++;
  endtask

  task automatic test_reset_mid_frame;
    int          t0;
    logic [31:0] rd;
    logic        sel;
    store(TXDATA, 32'hA5);
    t0 = cyc;
    while (cyc < t0 + 2 + 4 * C) @(negedge clk);
    n_checks++;
    if (tx_busy !== 1'b1 || tx !== 1'b0)
      $display("FAIL mid_data_bit3: got busy=%b tx=%b expected busy=1 tx=0", tx_busy, tx);
    else n_pass++;
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (tx !== 1'b1) $display("FAIL mid_reset_tx: got %b expected 1", tx); else n_pass++;
    n_checks++;
    if (tx_busy !== 1'b0) $display("FAIL mid_reset_busy: got %b expected 0", tx_busy); else n_pass++;
    repeat (2) @(negedge clk);
    rx_start_q.delete();
    rx_q.delete();
    reset = 1'b1;
    @(negedge clk);
    load(STATUS, rd, sel);
    n_checks++;
    if (rd !== 32'h2) $display("FAIL mid_status: got %h expected 00000002", rd); else n_pass++;
    repeat (12 * C) @(negedge clk);
    n_checks++;
    if (rx_start_q.size() != 0 || rx_q.size() != 0)
      $display("FAIL mid_residual: got %0d starts expected 0", rx_start_q.size());
    else n_pass++;
  endtask

  task automatic test_address_decode;
    logic [31:0] rd;
    logic        sel;
    logic [31:0] addrs[2];
    addrs[0] = 32'hFFFF_0010;
    addrs[1] = 32'h0000_0000;
    for (int k = 0; k < 2; k++) begin
      bus.Mem_WrAddr = addrs[k];
      bus.Mem_WrData = 32'h41;
      bus.MemWrite   = 1'b1;
      #1;
      n_checks++;
      if (bus.io_sel !== 1'b0 || bus.io_rdata !== 32'h0)
        $display("FAIL decode_sel%0d: got sel=%b rdata=%h expected sel=0 rdata=0", k, bus.io_sel, bus.io_rdata);
      else n_pass++;
      @(negedge clk);
      bus.MemWrite = 1'b0;
    end
    repeat (4 * C) @(negedge clk);
    n_checks++;
    if (tx !== 1'b1 || rx_start_q.size() != 0)
      $display("FAIL decode_tx_idle: got tx=%b starts=%0d expected tx=1 starts=0", tx, rx_start_q.size());
    else n_pass++;
    load(32'hFFFF_0008, rd, sel);
    n_checks++;
    if (rd !== 32'h0 || sel !== 1'b1)
      $display("FAIL decode_reserved: got sel=%b rdata=%h expected sel=1 rdata=0", sel, rd);
    else n_pass++;
    load(TXDATA, rd, sel);
    n_checks++;
    if (rd !== 32'h0 || sel !== 1'b1)
      $display("FAIL decode_txdata_read: got sel=%b rdata=%h expected sel=1 rdata=0", sel, rd);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_fill_overflow();
    test_clear_overflow();
    test_back_to_back();
    test_reset_mid_frame();
    test_address_decode();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", n_pass, n_checks);
    $fatal(1);
  end

endmodule
`default_nettype wire
